// File: rtl/vga_timing_pkg.sv
// Shared phase encoding and default 640x480@60 timing constants for the VGA sync path.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACT,
    PH_FP,
    PH_SY,
    PH_BP
  } phase_e;

  localparam int POS_W      = 10;
  localparam int CELL_WIDTH = 8;
  localparam int CELL_BITS  = 3;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF  = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BACK_DEF   = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BACK_DEF   = 33;

endpackage

// File: rtl/vga_phase_counter.sv
// Position counter plus ACT/FP/SY/BP phase FSM; used once per axis.
module vga_phase_counter
  import vga_timing_pkg::*;
#(
  parameter int ACT_LEN = 640,
  parameter int FP_LEN  = 16,
  parameter int SY_LEN  = 96,
  parameter int BP_LEN  = 48
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             advance,
  output logic [POS_W-1:0] position,
  output phase_e           phase,
  output logic             wrap
);

  // Last position of each phase; BP ends on the wrap position.
  localparam logic [POS_W-1:0] ACT_END = POS_W'(ACT_LEN - 1);
  localparam logic [POS_W-1:0] FP_END  = POS_W'(ACT_LEN + FP_LEN - 1);
  localparam logic [POS_W-1:0] SY_END  = POS_W'(ACT_LEN + FP_LEN + SY_LEN - 1);
  localparam logic [POS_W-1:0] TOT_END = POS_W'(ACT_LEN + FP_LEN + SY_LEN + BP_LEN - 1);

  logic [POS_W-1:0] pos_q, pos_d;
  phase_e           phase_q, phase_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pos_q   <= '0;
      phase_q <= PH_ACT;
    end else begin
      pos_q   <= pos_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    wrap    = (pos_q == TOT_END);
    pos_d   = pos_q;
    phase_d = phase_q;
    if (advance) begin
      pos_d = wrap ? '0 : pos_q + 1'b1;
      case (phase_q)
        PH_ACT: if (pos_q == ACT_END) phase_d = PH_FP;
        PH_FP:  if (pos_q == FP_END)  phase_d = PH_SY;
        PH_SY:  if (pos_q == SY_END)  phase_d = PH_BP;
        PH_BP:  if (wrap)             phase_d = PH_ACT;
      endcase
    end
  end

  assign position = pos_q;
  assign phase    = phase_q;

endmodule

// File: rtl/vga_sync_generator.sv
// VGA HSYNC/VSYNC, cell pixel count and raster position, all registered one cycle after the counters.
// Optional macro VGA_PIXEL_CE_EN adds a pixel_ce clock-enable input.
module vga_sync_generator
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FRONT  = H_FRONT_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FRONT  = V_FRONT_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BACK   = V_BACK_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
`ifdef VGA_PIXEL_CE_EN
  input  logic             pixel_ce,
`endif
  output logic             HSYNC,
  output logic             VSYNC,
  output logic [2:0]       count,
  output logic             display_enable,
  output logic [9:0]       pixel_x,
  output logic [9:0]       pixel_y,
  output logic             frame_start
);

  logic ce;
`ifdef VGA_PIXEL_CE_EN
  assign ce = pixel_ce;
`else
  assign ce = 1'b1;
`endif

  logic [POS_W-1:0] h_pos, v_pos;
  phase_e           h_phase, v_phase;
  logic             h_wrap, unused_v_wrap;

  vga_phase_counter #(
    .ACT_LEN(H_ACTIVE), .FP_LEN(H_FRONT), .SY_LEN(H_SYNC), .BP_LEN(H_BACK)
  ) u_h (
    .clock(clock), .reset_n(reset_n), .advance(ce),
    .position(h_pos), .phase(h_phase), .wrap(h_wrap)
  );

  vga_phase_counter #(
    .ACT_LEN(V_ACTIVE), .FP_LEN(V_FRONT), .SY_LEN(V_SYNC), .BP_LEN(V_BACK)
  ) u_v (
    .clock(clock), .reset_n(reset_n), .advance(ce & h_wrap),
    .position(v_pos), .phase(v_phase), .wrap(unused_v_wrap)
  );

  logic             hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, fs_q, fs_d;
  logic [2:0]       count_q, count_d;
  logic [POS_W-1:0] px_q, px_d, py_q, py_d;

  // frame_start is a single-clock pulse even when pixel_ce stretches the other outputs.
  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    de_d    = de_q;
    count_d = count_q;
    px_d    = px_q;
    py_d    = py_q;
    fs_d    = 1'b0;
    if (ce) begin
      hsync_d = (h_phase != PH_SY);
      vsync_d = (v_phase != PH_SY);
      de_d    = (h_phase == PH_ACT) && (v_phase == PH_ACT);
      count_d = de_d ? h_pos[CELL_BITS-1:0] : '0;
      px_d    = h_pos;
      py_d    = v_pos;
      fs_d    = (h_pos == '0) && (v_pos == '0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      count_q <= '0;
      px_q    <= '0;
      py_q    <= '0;
      fs_q    <= 1'b0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      count_q <= count_d;
      px_q    <= px_d;
      py_q    <= py_d;
      fs_q    <= fs_d;
    end
  end

  assign HSYNC          = hsync_q;
  assign VSYNC          = vsync_q;
  assign count          = count_q;
  assign display_enable = de_q;
  assign pixel_x        = px_q;
  assign pixel_y        = py_q;
  assign frame_start    = fs_q;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: default 640x480 instance and a tiny-timing instance checked against an arithmetic raster model.
module tb_vga_sync_generator;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [2:0] cnt;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       fs;
  } obs_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

`ifdef VGA_PIXEL_CE_EN
  logic pixel_ce = 1'b1;
`endif

  logic       b_hs, b_vs, b_de, b_fs, s_hs, s_vs, s_de, s_fs;
  logic [2:0] b_cnt, s_cnt;
  logic [9:0] b_x, b_y, s_x, s_y;

  vga_sync_generator u_big (
    .clock(clock), .reset_n(reset_n),
`ifdef VGA_PIXEL_CE_EN
    .pixel_ce(pixel_ce),
`endif
    .HSYNC(b_hs), .VSYNC(b_vs), .count(b_cnt), .display_enable(b_de),
    .pixel_x(b_x), .pixel_y(b_y), .frame_start(b_fs)
  );

  vga_sync_generator #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_small (
    .clock(clock), .reset_n(reset_n),
`ifdef VGA_PIXEL_CE_EN
    .pixel_ce(pixel_ce),
`endif
    .HSYNC(s_hs), .VSYNC(s_vs), .count(s_cnt), .display_enable(s_de),
    .pixel_x(s_x), .pixel_y(s_y), .frame_start(s_fs)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Run statistics gathered by run_episode
  int sevens_line0, hs_low_line0, vs_low_small, fs_small;

  // Raster model: output k cycles after reset release shows pixel k of the frame sequence.
  function automatic obs_t model(input int ha, hf, hsw, hb, va, vf, vsw, vb, input int k);
    obs_t o;
    int ht, vt, x, y;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    x = k % ht;
    y = (k / ht) % vt;
    o.x   = 10'(x);
    o.y   = 10'(y);
    o.de  = (x < ha) && (y < va);
    o.hs  = !((x >= ha + hf) && (x < ha + hf + hsw));
    o.vs  = !((y >= va + vf) && (y < va + vf + vsw));
    o.cnt = o.de ? 3'(x % 8) : 3'd0;
    o.fs  = (x == 0) && (y == 0);
    return o;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s k=%0d: observed %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic chk_obs(input string who, input int k, input obs_t got, input obs_t exp);
    chk({who, ".HSYNC"}, k, 32'(got.hs), 32'(exp.hs));
    chk({who, ".VSYNC"}, k, 32'(got.vs), 32'(exp.vs));
    chk({who, ".count"}, k, 32'(got.cnt), 32'(exp.cnt));
    chk({who, ".display_enable"}, k, 32'(got.de), 32'(exp.de));
    chk({who, ".pixel_x"}, k, 32'(got.x), 32'(exp.x));
    chk({who, ".pixel_y"}, k, 32'(got.y), 32'(exp.y));
    chk({who, ".frame_start"}, k, 32'(got.fs), 32'(exp.fs));
  endtask

  function automatic obs_t big_obs();
    return '{hs: b_hs, vs: b_vs, cnt: b_cnt, de: b_de, x: b_x, y: b_y, fs: b_fs};
  endfunction

  function automatic obs_t small_obs();
    return '{hs: s_hs, vs: s_vs, cnt: s_cnt, de: s_de, x: s_x, y: s_y, fs: s_fs};
  endfunction

  // Release reset, check n cycles, then assert reset mid-cycle and check it takes effect before any edge.
  task automatic run_episode(input int n);
    obs_t bo, so;
    sevens_line0 = 0;
    hs_low_line0 = 0;
    vs_low_small = 0;
    fs_small     = 0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      bo = big_obs();
      so = small_obs();
      chk_obs("big", k, bo, model(640, 16, 96, 48, 480, 10, 2, 33, k));
      chk_obs("small", k, so, model(8, 2, 2, 2, 2, 1, 1, 1, k));
      if (k < 800 && bo.cnt == 3'd7) sevens_line0++;
      if (k < 800 && !bo.hs) hs_low_line0++;
      if (k < 70 && !so.vs) vs_low_small++;
      if (k >= 1 && k <= 70 && so.fs) fs_small++;
    end
    #2 reset_n = 1'b0;
    #1;
    chk_obs("big.async_rst", n, big_obs(), reset_obs());
    chk_obs("small.async_rst", n, small_obs(), reset_obs());
    @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk_obs("big.reset", -1, big_obs(), reset_obs());
    chk_obs("small.reset", -1, small_obs(), reset_obs());

    // Three full lines of the default timing and many small frames
    run_episode(2400);
    chk("big.count7_per_line", 0, 32'(sevens_line0), 32'd80);
    chk("big.hsync_low_clocks", 0, 32'(hs_low_line0), 32'd96);
    chk("small.vsync_low_clocks", 0, 32'(vs_low_small), 32'd14);
    chk("small.frame_start_pulses", 0, 32'(fs_small), 32'd1);

    // Ends on pixel_x=700, inside HSYNC, before the async reset
    run_episode(701);

    repeat (6) run_episode(int'($urandom_range(1, 1500)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
